// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants and types for the PS/2 keyboard receiver.
//   PS2_BREAK / PS2_EXT    : set-2 prefix bytes (key release / extended key)
//   PS2_TARGET_DEFAULT     : default make code watched by ps2_key_decoder
//   ps2_state_t            : frame receiver FSM encoding
//   ps2_parity_ok()        : odd-parity check over 8 data bits + parity bit
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK          = 8'hF0;
    localparam logic [7:0] PS2_EXT            = 8'hE0;
    localparam logic [7:0] PS2_TARGET_DEFAULT = 8'h1C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Odd parity: the nine bits together must hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Bit-level PS/2 device-to-host receiver: synchronizes the keyboard clock and
// data, detects falling edges of the keyboard clock, assembles the 11-bit
// frame, checks parity/stop and aborts a frame that stalls for too long.
//   CLOCK_50  in  : system clock, rising edge
//   reset     in  : synchronous, active-high
//   ps2_clk   in  : asynchronous keyboard clock (idle high)
//   ps2_dat   in  : asynchronous keyboard data (idle high)
//   rx_byte   out : last correctly received byte
//   rx_valid  out : one-cycle pulse, rx_byte just updated
//   rx_error  out : one-cycle pulse, a frame was discarded
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Synchronizers; reset to the bus idle level so no false edge follows reset.
    logic ps2_clk_s1, ps2_clk_s2, ps2_clk_d;
    logic ps2_dat_s1, ps2_dat_s2;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ps2_clk_s1 <= 1'b1;
            ps2_clk_s2 <= 1'b1;
            ps2_clk_d  <= 1'b1;
            ps2_dat_s1 <= 1'b1;
            ps2_dat_s2 <= 1'b1;
        end else begin
            ps2_clk_s1 <= ps2_clk;
            ps2_clk_s2 <= ps2_clk_s1;
            ps2_clk_d  <= ps2_clk_s2;
            ps2_dat_s1 <= ps2_dat;
            ps2_dat_s2 <= ps2_dat_s1;
        end
    end

    logic fall;
    logic bit_in;

    assign fall   = ps2_clk_d & ~ps2_clk_s2;
    assign bit_in = ps2_dat_s2;

    ps2_state_t  state, state_nxt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bit;
    logic [15:0] to_cnt;
    logic        timeout;

    // An edge in the same cycle restarts the wait, so timeout never coincides
    // with a stop edge and valid/error stay mutually exclusive.
    assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);

    // FSM state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = ST_IDLE;
        end else if (fall) begin
            case (state)
                ST_IDLE:   if (!bit_in) state_nxt = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM outputs
    logic shift_en, par_en, stop_edge, frame_ok, frame_bad;

    always_comb begin
        shift_en  = fall && (state == ST_DATA);
        par_en    = fall && (state == ST_PARITY);
        stop_edge = fall && (state == ST_STOP);
        frame_ok  = stop_edge && bit_in && ps2_parity_ok(shreg, par_bit);
        frame_bad = (stop_edge && !frame_ok) || timeout;
    end

    // Datapath: data shifts in LSB first, so new bits enter at the top.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            par_bit  <= 1'b0;
            to_cnt   <= 16'd0;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_valid <= frame_ok;
            rx_error <= frame_bad;
            if (frame_ok) rx_byte <= shreg;

            if (timeout)       bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

            if (shift_en) shreg   <= {bit_in, shreg[7:1]};
            if (par_en)   par_bit <= bit_in;

            if (fall || timeout || state == ST_IDLE) to_cnt <= 16'd0;
            else                                     to_cnt <= to_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Tracks the held state of one set-2 key from a PS/2 keyboard.
//   TARGET_CODE     : make code of the watched key
//   TIMEOUT_CYCLES  : idle CLOCK_50 cycles tolerated inside a frame
//   CLOCK_50        in  : 50 MHz system clock
//   reset           in  : synchronous, active-high
//   PS2_CLK/PS2_DAT in  : keyboard bus
//   a_key_pressed   out : 0 while TARGET_CODE is held, 1 otherwise
//   scan_code       out : last correctly received byte
//   code_valid      out : one-cycle pulse on scan_code update
//   frame_error     out : one-cycle pulse on a discarded frame
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter logic [7:0] TARGET_CODE    = PS2_TARGET_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       a_key_pressed,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_error
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_error;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .ps2_clk (PS2_CLK),
        .ps2_dat (PS2_DAT),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_error(rx_error)
    );

    assign scan_code   = rx_byte;
    assign code_valid  = rx_valid;
    assign frame_error = rx_error;

    logic ext_flag, break_flag;
    logic is_prefix, hit;
    logic key_up_q, key_up_nxt;

    assign is_prefix = (rx_byte == PS2_EXT) || (rx_byte == PS2_BREAK);
    assign hit       = rx_valid && !is_prefix && (rx_byte == TARGET_CODE) && !ext_flag;

    // The key level is presented combinationally from the registered state so
    // it changes in the very cycle code_valid pulses; a repeated make code
    // recomputes the same 0, so typematic repeats cannot glitch it.
    always_comb begin
        key_up_nxt = key_up_q;
        if (hit) key_up_nxt = break_flag;
    end

    assign a_key_pressed = key_up_nxt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_up_q   <= 1'b1;
            ext_flag   <= 1'b0;
            break_flag <= 1'b0;
        end else begin
            key_up_q <= key_up_nxt;
            if (rx_error) begin
                // A broken frame may have been the byte a prefix was waiting for.
                ext_flag   <= 1'b0;
                break_flag <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == PS2_BREAK) begin
                    break_flag <= 1'b1;
                end else begin
                    ext_flag   <= 1'b0;
                    break_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: frames are driven bit by bit, the
// expected outcome of each frame is queued, and a monitor compares every
// code_valid / frame_error pulse against the head of the queue.
module tb_ps2_key_decoder;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic       a_key_pressed;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_error;

    ps2_key_decoder dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .PS2_CLK      (PS2_CLK),
        .PS2_DAT      (PS2_DAT),
        .a_key_pressed(a_key_pressed),
        .scan_code    (scan_code),
        .code_valid   (code_valid),
        .frame_error  (frame_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       is_err;
        logic [7:0] scan;
        logic       key;
    } exp_t;

    typedef struct {
        logic [7:0] code;
        logic       flip;     // corrupt the parity bit
        logic       stop;     // stop bit value to send
        logic       exp_err;
        logic [7:0] exp_scan;
        logic       exp_key;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[18];
    int   checks = 0;
    int   errors = 0;

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0b want=%0b t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%02h want=%02h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip, input logic stop);
        return {stop, (~^d) ^ flip, d, 1'b0};
    endfunction

    // Drives the first n bits of a frame; the keyboard changes data while its
    // clock is high and the host samples on the falling edge.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = f[i];
            tick(4);
            PS2_CLK = 1'b0;
            tick(8);
            PS2_CLK = 1'b1;
            tick(4);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout pending=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Pulse monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            if (code_valid || frame_error) begin
                check1("pulse_exclusive", code_valid && frame_error, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse valid=%0b err=%0b want=none t=%0t",
                             code_valid, frame_error, $time);
                end else begin
                    e = exp_q.pop_front();
                    check1("pulse_is_error", frame_error, e.is_err);
                    check8("scan_code", scan_code, e.scan);
                    check1("a_key_pressed", a_key_pressed, e.key);
                end
            end
        end
    end

    initial begin
        //          code   flip  stop  err   scan   key
        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0};  // make
        vecs[1]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0};  // typematic
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0};
        vecs[3]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0};
        vecs[4]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1};  // break
        vecs[5]  = '{8'h1C, 1'b1, 1'b1, 1'b1, 8'h1C, 1'b1};  // bad parity
        vecs[6]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b1};
        vecs[7]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1};  // extended: ignored
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0};
        vecs[9]  = '{8'h2A, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0};  // other key
        vecs[10] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0};
        vecs[11] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0};  // bad stop after F0
        vecs[12] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0};  // break flag was cleared
        vecs[13] = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b0};
        vecs[14] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0};
        vecs[15] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b0};  // E0 F0 1C: not ours
        vecs[16] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0};
        vecs[17] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C, 1'b1};

        // Reset state
        tick(3);
        check1("rst_key", a_key_pressed, 1'b1);
        check8("rst_scan", scan_code, 8'h00);
        check1("rst_valid", code_valid, 1'b0);
        check1("rst_err", frame_error, 1'b0);
        reset = 1'b0;
        tick(5);

        for (int i = 0; i < 18; i++) begin
            exp_q.push_back('{vecs[i].exp_err, vecs[i].exp_scan, vecs[i].exp_key});
            send_bits(mk_frame(vecs[i].code, vecs[i].flip, vecs[i].stop), 11);
            wait_drain("vec_drain", 500);
        end

        // Stalled frame: exactly one error, then normal reception.
        exp_q.push_back('{1'b1, 8'h1C, 1'b1});
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5);
        wait_drain("timeout_drain", 60000);
        tick(2000);
        exp_q.push_back('{1'b0, 8'h1C, 1'b0});
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
        wait_drain("post_timeout_drain", 500);

        // Reset in mid-frame: no pulse, outputs return to reset values.
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 6);
        reset = 1'b1;
        tick(1);
        check1("midrst_key", a_key_pressed, 1'b1);
        check8("midrst_scan", scan_code, 8'h00);
        check1("midrst_valid", code_valid, 1'b0);
        check1("midrst_err", frame_error, 1'b0);
        reset = 1'b0;
        tick(20);
        exp_q.push_back('{1'b0, 8'h2A, 1'b1});
        send_bits(mk_frame(8'h2A, 1'b0, 1'b1), 11);
        wait_drain("post_reset_drain", 500);
        tick(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TARGET_CODE, default 8'h1C; set-2 make code of the key whose held state drives a_key_pressed.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000; idle CLOCK_50 cycles, about 1 ms, allowed between PS/2 clock falling edges inside a frame.
REQ-003 SHALL have port CLOCK_50, input, 1 bit; the only clock, 50 MHz, rising edge.
REQ-004 SHALL have port reset, input, 1 bit; one clock, reset synchronous and active-high.
REQ-005 SHALL have port PS2_CLK, input, 1 bit; asynchronous keyboard clock, idle high.
REQ-006 SHALL have port PS2_DAT, input, 1 bit; asynchronous keyboard data, idle high.
REQ-007 SHALL have port a_key_pressed, output, 1 bit; active-low level, 0 while TARGET_CODE is held and 1 otherwise.
REQ-008 SHALL have port scan_code, output, 8 bits; last correctly received byte.
REQ-009 SHALL have port code_valid, output, 1 bit; one-cycle pulse when scan_code updates.
REQ-010 SHALL have port frame_error, output, 1 bit; one-cycle pulse when a frame is discarded.

Function
REQ-011 SHALL pass PS2_CLK and PS2_DAT through two-flop synchronizers; falling edge = previous synced clock 1 and current synced clock 0.
REQ-012 SHALL sample synced PS2_DAT only in the cycle a falling edge is detected.
REQ-013 Frame: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1; 11 falling edges in total.
REQ-014 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP; transitions below.
- IDLE->DATA: edge with data 0.
- IDLE stays IDLE: edge with data 1, no error.
- DATA->PARITY: after the 8th data edge; a 3-bit bit counter wraps 7->0.
- PARITY->STOP: on the parity edge.
- STOP->IDLE: on the stop edge.
REQ-015 At the stop edge, if stop=1 and the XOR of the 8 data bits and parity is 1: scan_code updates and code_valid pulses, both in the cycle after that edge.
REQ-016 Otherwise (bad parity or stop=0): scan_code unchanged, frame_error pulses in the cycle after that edge, FSM returns to IDLE.
REQ-017 A 16-bit timeout counter SHALL clear on every detected edge and increment each cycle while the FSM is not IDLE.
REQ-018 On reaching TIMEOUT_CYCLES-1: FSM to IDLE, partial byte discarded, frame_error pulses once, break_flag and ext_flag clear.
REQ-019 Protocol layer acts on each valid byte.
- 8'hE0 sets ext_flag.
- 8'hF0 sets break_flag.
- Any other byte clears both flags after being evaluated.
REQ-020 A non-prefix byte equal to TARGET_CODE with ext_flag=0 drives a_key_pressed: 0 if break_flag=0, 1 if break_flag=1; the update happens in the same cycle code_valid pulses.
REQ-021 Repeated make codes (typematic) SHALL keep a_key_pressed at 0 with no glitch; other keys and extended codes (E0 1C) SHALL leave a_key_pressed unchanged.
REQ-022 A frame error in mid-sequence (e.g. after F0) SHALL clear both flags; a_key_pressed is unchanged.
REQ-023 code_valid SHALL pulse for prefix bytes E0 and F0 as well.
REQ-024 code_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-025 While reset=1 at a CLOCK_50 edge: a_key_pressed=1, scan_code=8'h00, code_valid=0, frame_error=0.
REQ-026 While reset=1 at a CLOCK_50 edge: FSM=IDLE, bit counter=0, timeout counter=0, flags=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no code_valid or frame_error pulse.
REQ-028 After reset release, reception SHALL resume at the next start bit.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0, the frame FSM state encoding, and the default TARGET_CODE.
REQ-030 Bit-level reception (synchronizers, edge detect, FSM, parity, timeout) SHALL be sub-module ps2_frame_rx, exporting byte, valid, error.
REQ-031 Top-level ps2_key_decoder SHALL hold only the flag logic and a_key_pressed.

Verification
REQ-032 Send frame 1C with parity 0 -> code_valid pulse, scan_code=1C, a_key_pressed 1->0 in the same cycle.
REQ-033 Send 1C, 1C, 1C, then F0, 1C -> a_key_pressed stays 0 through the repeats; goes to 1 on the final 1C; four code_valid pulses before it.
REQ-034 Send byte 1C with parity bit 1 -> frame_error pulse, no code_valid, scan_code and a_key_pressed unchanged.
REQ-035 Send E0, 1C -> scan_code=1C, a_key_pressed stays 1; a following plain 1C -> a_key_pressed=0.
REQ-036 Stop PS2_CLK after 5 edges for 50000 cycles -> exactly one frame_error pulse, FSM IDLE; the next full 1C frame decodes correctly.
REQ-037 Assert reset for 1 cycle after the 6th edge of a 1C frame -> no pulses, outputs at reset values; the next frame 2A gives scan_code=2A, a_key_pressed=1.
